// File: rtl/qick_xcom_rx.sv
//------------------------------------------------------------------------------
// qick_xcom_rx
//
// Single-channel XCOM link receiver. Recovers {op, id, data} frames from the
// ck/dt pair driven by a remote board's XCOM transmitter. Every transition of
// the remote ck (rising or falling) carries one bit, sampled from dt.
//
// Frame, MSB first: start bit (1), 8 header bits {op[3:0], id[3:0]}, then a
// payload whose length is chosen by op[1:0]: 00->0, 01->8, 10->16, 11->32.
//
// Ports
//   x_clk_i    link clock, all logic on its rising edge
//   x_rst_ni   asynchronous active-low reset
//   rx_en_i    receiver enable (synchronous to x_clk_i)
//   rx_ck_i    remote link clock (asynchronous)
//   rx_dt_i    remote link data (asynchronous)
//   rx_vld_o   one-cycle pulse, frame complete (op/id/dt valid from this cycle)
//   rx_op_o    received opcode, held until the next complete frame
//   rx_id_o    sender board id, held until the next complete frame
//   rx_dt_o    payload, right-aligned and zero-extended
//   rx_err_o   one-cycle pulse, frame aborted by inter-bit timeout
//   rx_busy_o  high while in HEADER or DATA
//   frm_cnt_o  count of good frames, wraps 255->0
//
// Handshake: there is no back-pressure. rx_vld_o is a single-cycle strobe and
// the consumer must take rx_op_o/rx_id_o/rx_dt_o in that cycle or later, before
// the next strobe; the values stay stable between strobes.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module qick_xcom_rx #(
   parameter int TOUT    = 255,  // inter-bit timeout in x_clk cycles (8..65535)
   parameter int SYNC_FF = 2     // synchronizer depth, 2 or 3
) (
   input  logic        x_clk_i,
   input  logic        x_rst_ni,
   input  logic        rx_en_i,
   input  logic        rx_ck_i,
   input  logic        rx_dt_i,
   output logic        rx_vld_o,
   output logic [3:0]  rx_op_o,
   output logic [3:0]  rx_id_o,
   output logic [31:0] rx_dt_o,
   output logic        rx_err_o,
   output logic        rx_busy_o,
   output logic [7:0]  frm_cnt_o
);

   localparam int TW = $clog2(TOUT + 1);
   // The counter reads i in the i-th cycle after an edge cycle, so seeing
   // TOUT-2 here means the count reaches TOUT-1 in the cycle the error shows.
   localparam logic [TW-1:0] TOUT_FIRE = TW'(TOUT - 2);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HEADER = 2'd1,
      ST_DATA   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [SYNC_FF-1:0]   ck_sync_q, ck_sync_d;
   logic [SYNC_FF-1:0]   dt_sync_q, dt_sync_d;
   logic                 ck_q, ck_d;
   logic [7:0]           hdr_q, hdr_d;
   logic [31:0]          sh_q, sh_d;
   logic [5:0]           bit_cnt_q, bit_cnt_d;
   logic [TW-1:0]        tout_q, tout_d;
   logic                 vld_q, vld_d;
   logic                 err_q, err_d;
   logic [3:0]           op_q, op_d;
   logic [3:0]           id_q, id_d;
   logic [31:0]          dat_q, dat_d;
   logic [7:0]           cnt_q, cnt_d;

   logic                 ck_s;
   logic                 rx_bit;
   logic                 rx_edge;
   logic                 frame_end;
   logic [5:0]           last_bit;

   assign ck_s    = ck_sync_q[SYNC_FF-1];
   assign rx_bit  = dt_sync_q[SYNC_FF-1];
   assign rx_edge = ck_s ^ ck_q;

   // Index of the final payload bit, from the latched header's op[1:0].
   always_comb begin
      case (hdr_q[5:4])
         2'b01:   last_bit = 6'd7;
         2'b10:   last_bit = 6'd15;
         default: last_bit = 6'd31;
      endcase
   end

   always_comb begin
      // Synchronizers run regardless of enable so that re-enabling never
      // sees a stale ck level as a false edge.
      ck_sync_d = {ck_sync_q[SYNC_FF-2:0], rx_ck_i};
      dt_sync_d = {dt_sync_q[SYNC_FF-2:0], rx_dt_i};
      ck_d      = ck_s;

      state_d   = state_q;
      hdr_d     = hdr_q;
      sh_d      = sh_q;
      bit_cnt_d = bit_cnt_q;
      tout_d    = tout_q;
      vld_d     = 1'b0;
      err_d     = 1'b0;
      op_d      = op_q;
      id_d      = id_q;
      dat_d     = dat_q;
      cnt_d     = cnt_q;
      frame_end = 1'b0;

      if (!rx_en_i) begin
         // Silent abort: no error pulse, edges ignored.
         state_d = ST_IDLE;
         tout_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               tout_d = '0;
               if (rx_edge && rx_bit) begin
                  state_d   = ST_HEADER;
                  bit_cnt_d = 6'd0;
                  hdr_d     = 8'd0;
                  sh_d      = 32'd0;
               end
            end

            ST_HEADER, ST_DATA: begin
               if (rx_edge) begin
                  tout_d    = TW'(1);
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  if (state_q == ST_HEADER) begin
                     hdr_d = {hdr_q[6:0], rx_bit};
                     if (bit_cnt_q == 6'd7) begin
                        bit_cnt_d = 6'd0;
                        if (hdr_d[5:4] == 2'b00) begin
                           state_d   = ST_DONE;
                           frame_end = 1'b1;
                        end else begin
                           state_d = ST_DATA;
                        end
                     end
                  end else begin
                     sh_d = {sh_q[30:0], rx_bit};
                     if (bit_cnt_q == last_bit) begin
                        state_d   = ST_DONE;
                        frame_end = 1'b1;
                     end
                  end
               end else if (tout_q == TOUT_FIRE) begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
                  tout_d  = '0;
               end else begin
                  tout_d = tout_q + TW'(1);
               end
            end

            // Edges landing here are dropped; the transmitter leaves a full
            // idle bit period between frames.
            ST_DONE: begin
               state_d = ST_IDLE;
               tout_d  = '0;
            end

            default: begin
               state_d = ST_IDLE;
               tout_d  = '0;
            end
         endcase
      end

      // Outputs load with the strobe so they are valid in the DONE cycle.
      // The shift register was cleared on HEADER entry, so short payloads
      // come out zero-extended.
      if (frame_end) begin
         vld_d = 1'b1;
         op_d  = hdr_d[7:4];
         id_d  = hdr_d[3:0];
         dat_d = sh_d;
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge x_clk_i or negedge x_rst_ni) begin
      if (!x_rst_ni) begin
         state_q   <= ST_IDLE;
         ck_sync_q <= '0;
         dt_sync_q <= '0;
         ck_q      <= 1'b0;
         hdr_q     <= 8'd0;
         sh_q      <= 32'd0;
         bit_cnt_q <= 6'd0;
         tout_q    <= '0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
         op_q      <= 4'd0;
         id_q      <= 4'd0;
         dat_q     <= 32'd0;
         cnt_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         ck_sync_q <= ck_sync_d;
         dt_sync_q <= dt_sync_d;
         ck_q      <= ck_d;
         hdr_q     <= hdr_d;
         sh_q      <= sh_d;
         bit_cnt_q <= bit_cnt_d;
         tout_q    <= tout_d;
         vld_q     <= vld_d;
         err_q     <= err_d;
         op_q      <= op_d;
         id_q      <= id_d;
         dat_q     <= dat_d;
         cnt_q     <= cnt_d;
      end
   end

   assign rx_vld_o  = vld_q;
   assign rx_err_o  = err_q;
   assign rx_op_o   = op_q;
   assign rx_id_o   = id_q;
   assign rx_dt_o   = dat_q;
   assign frm_cnt_o = cnt_q;
   assign rx_busy_o = (state_q == ST_HEADER) || (state_q == ST_DATA);

endmodule
